pipe_pc_fd: RTL and testbench

// - F/D pipeline register: captures fetched PC, instruction, fetch exception code and delay-slot flag at the
//   IF->ID boundary; its PC_out feeds the D/E PC register. Performs fetch address-error (AdEL) detection,

---
 rtl/pipe_pc_fd.sv | 111 +++++++++++
 tb/tb_pipe_pc_fd.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_pc_fd.sv
// rtl/pipe_pc_fd.sv - F/D pipeline register with fetch address-error check
// Optional stall/flush event counters are compiled in with FD_PERF_CNT_EN.
module pipe_pc_fd #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_SIZE  = 32'h0000_4000,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stopen,
  input  logic        flush,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instr_in,
  input  logic        BD_in,
  output logic [31:0] PC_out,
  output logic [31:0] Instr_out,
  output logic [4:0]  ExcCode_out,
  output logic        BD_out,
  output logic        Valid_out
`ifdef FD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  // Upper bound held in 33 bits so a memory ending at 2^32 does not wrap.
  localparam logic [32:0] IM_LAST = {1'b0, IM_BASE} + {1'b0, IM_SIZE} - 33'd1;

  logic        adel;
  logic [31:0] pc_d, pc_q;
  logic [31:0] instr_d, instr_q;
  logic [4:0]  exc_d, exc_q;
  logic        bd_d, bd_q;
  logic        valid_d, valid_q;

  always_comb begin
    adel = (PC_in[1:0] != 2'b00) | (PC_in < IM_BASE) | ({1'b0, PC_in} > IM_LAST);
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = RESET_PC;
      instr_d = 32'h0;
      exc_d   = 5'd0;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (!stopen) begin
      // A faulting fetch still carries its PC forward as the EPC source.
      pc_d    = PC_in;
      instr_d = adel ? 32'h0 : Instr_in;
      exc_d   = adel ? EXC_ADEL : 5'd0;
      bd_d    = BD_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      exc_q   <= 5'd0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end

  assign PC_out      = pc_q;
  assign Instr_out   = instr_q;
  assign ExcCode_out = exc_q;
  assign BD_out      = bd_q;
  assign Valid_out   = valid_q;

`ifdef FD_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stopen && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_pc_fd.sv
// tb/tb_pipe_pc_fd.sv - self-checking bench for pipe_pc_fd (table vectors plus randomized model check)
module tb_pipe_pc_fd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stopen = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] PC_in = 32'h0;
  logic [31:0] Instr_in = 32'h0;
  logic        BD_in = 1'b0;
  logic [31:0] PC_out;
  logic [31:0] Instr_out;
  logic [4:0]  ExcCode_out;
  logic        BD_out;
  logic        Valid_out;
`ifdef FD_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_pc_fd dut (
    .clk(clk), .reset(reset), .stopen(stopen), .flush(flush),
    .PC_in(PC_in), .Instr_in(Instr_in), .BD_in(BD_in),
    .PC_out(PC_out), .Instr_out(Instr_out), .ExcCode_out(ExcCode_out),
    .BD_out(BD_out), .Valid_out(Valid_out)
`ifdef FD_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  typedef struct {
    logic        rst, stl, fl;
    logic [31:0] pc, ins;
    logic        bd;
    logic [31:0] e_pc, e_ins;
    logic [4:0]  e_exc;
    logic        e_bd, e_v;
  } vec_t;

  vec_t tbl[15];

  // Reference model: outputs expected after the most recent edge.
  logic [31:0] m_pc, m_ins;
  logic [4:0]  m_exc;
  logic        m_bd, m_v;
  longint      m_stall, m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit fetch_bad(input logic [31:0] pc);
    longint a;
    a = longint'(pc);
    return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 64'h4000);
  endfunction

  task automatic model_step(input logic r, input logic s, input logic f,
                            input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    if (r) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (s && !f && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (f && m_flush < 64'hFFFF_FFFF) m_flush++;
    end
    if (r || f) begin
      m_pc = 32'h3000; m_ins = 0; m_exc = 0; m_bd = 0; m_v = 0;
    end else if (!s) begin
      m_pc  = pc;
      m_bd  = bd;
      m_v   = 1;
      m_exc = fetch_bad(pc) ? 5'd4 : 5'd0;
      m_ins = fetch_bad(pc) ? 32'h0 : ins;
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic f,
                       input logic [31:0] pc, input logic [31:0] ins, input logic bd);
    reset = r; stopen = s; flush = f; PC_in = pc; Instr_in = ins; BD_in = bd;
    @(posedge clk);
    model_step(r, s, f, pc, ins, bd);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    PC_out,             m_pc);
    check({tag, ".instr"}, Instr_out,          m_ins);
    check({tag, ".exc"},   {27'd0, ExcCode_out}, {27'd0, m_exc});
    check({tag, ".bd"},    {31'd0, BD_out},    {31'd0, m_bd});
    check({tag, ".valid"}, {31'd0, Valid_out}, {31'd0, m_v});
`ifdef FD_PERF_CNT_EN
    check({tag, ".stallcnt"}, StallCnt, m_stall[31:0]);
    check({tag, ".flushcnt"}, FlushCnt, m_flush[31:0]);
`endif
  endtask

  initial begin
    //            rst   stl   fl    pc            ins           bd    e_pc          e_ins         exc   ebd   ev
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0000_3004, 32'h1111_1111, 1'b1, 32'h0000_3000, 32'h0,        5'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h2408_0001, 1'b1, 32'h0000_3004, 32'h2408_0001, 5'd0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'hABCD_0001, 1'b0, 32'h0000_3004, 32'h2408_0001, 5'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'hABCD_0001, 1'b0, 32'h0000_3004, 32'h2408_0001, 5'd0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'hABCD_0001, 1'b0, 32'h0000_3004, 32'h2408_0001, 5'd0, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'hABCD_0001, 1'b0, 32'h0000_3008, 32'hABCD_0001, 5'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_300C, 32'h5555_5555, 1'b1, 32'h0000_3000, 32'h0,        5'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'hDEAD_BEEF, 1'b1, 32'h0000_3002, 32'h0,        5'd4, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 1'b0, 32'h0000_7000, 32'h0,        5'd4, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_6FFC, 32'h1234_5678, 1'b0, 32'h0000_6FFC, 32'h1234_5678, 5'd0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0000_2FFC, 32'h1234_5678, 1'b0, 32'h0000_2FFC, 32'h0,        5'd4, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_00AA, 1'b1, 32'h0000_3000, 32'h0000_00AA, 5'd0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h0000_3010, 32'h0000_00BB, 1'b1, 32'h0000_3000, 32'h0,        5'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 32'h0000_3010, 32'h0000_00BB, 1'b1, 32'h0000_3000, 32'h0,        5'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_00CC, 1'b0, 32'hFFFF_FFFC, 32'h0,        5'd4, 1'b0, 1'b1};

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].stl, tbl[i].fl, tbl[i].pc, tbl[i].ins, tbl[i].bd);
      check($sformatf("vec%0d.pc", i),    PC_out,               tbl[i].e_pc);
      check($sformatf("vec%0d.instr", i), Instr_out,            tbl[i].e_ins);
      check($sformatf("vec%0d.exc", i),   {27'd0, ExcCode_out}, {27'd0, tbl[i].e_exc});
      check($sformatf("vec%0d.bd", i),    {31'd0, BD_out},      {31'd0, tbl[i].e_bd});
      check($sformatf("vec%0d.valid", i), {31'd0, Valid_out},   {31'd0, tbl[i].e_v});
    end

    // Reset held across a flush, then loading resumes on the very next edge.
    apply(1'b1, 1'b0, 1'b1, 32'h0000_3020, 32'h0000_0001, 1'b0);
    check_model("rst_flush");
    apply(1'b0, 1'b0, 1'b0, 32'h0000_3024, 32'h0000_0002, 1'b1);
    check_model("resume");
    check("resume.pc_const", PC_out, 32'h0000_3024);

`ifdef FD_PERF_CNT_EN
    apply(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    for (int k = 0; k < 5; k++) apply(1'b0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 32'h0000_3000, 32'h0, 1'b0);
    check("perf.stall", StallCnt, 32'd5);
    check("perf.flush", FlushCnt, 32'd2);
    apply(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h0, 1'b0);
    check("perf.stall_rst", StallCnt, 32'd0);
    check("perf.flush_rst", FlushCnt, 32'd0);
`endif

    // Randomized run against the model, starting from a known reset.
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      logic r, s, f, bd;
      logic [31:0] pc, ins;
      r   = ($urandom_range(0, 31) == 0);
      f   = ($urandom_range(0, 7) == 0);
      s   = ($urandom_range(0, 3) == 0);
      bd  = 1'($urandom_range(0, 1));
      ins = $urandom();
      case ($urandom_range(0, 5))
        0: pc = $urandom();
        1: pc = 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
        2: pc = 32'h3000 + $urandom_range(0, 32'h3FFF);
        3: pc = 32'h2FFC + ($urandom_range(0, 1) << 2);
        4: pc = 32'h6FFC + ($urandom_range(0, 1) << 2);
        default: pc = 32'h6FF8 + $urandom_range(0, 15);
      endcase
      apply(r, s, f, pc, ins, bd);
      check_model($sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
